bpu_cnt_reader: RTL and testbench



---
 rtl/bpu_cnt_reader_pkg.sv | 24 ++
 rtl/bpu_cnt_timer.sv | 33 +++
 rtl/bpu_cnt_reader.sv | 167 ++++++++++++++++
 tb/tb_bpu_cnt_reader.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bpu_cnt_reader_pkg.sv
// Shared types and constants for the branch-statistics frame reader.
// Frame layout: header, five counters, then an XOR check word.
package bpu_cnt_reader_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    localparam int NCNT           = 5;
    localparam int NWORDS_DEFAULT = 7;

    localparam logic [2:0] IDX_HDR   = 3'd0;
    localparam logic [2:0] IDX_JB    = 3'd1;
    localparam logic [2:0] IDX_WRONG = 3'd2;
    localparam logic [2:0] IDX_J     = 3'd3;
    localparam logic [2:0] IDX_B     = 3'd4;
    localparam logic [2:0] IDX_R     = 3'd5;
    localparam logic [2:0] IDX_XOR   = 3'd6;

    localparam logic [15:0] HDR_LO        = 16'h0005;
    localparam logic [15:0] MAGIC_DEFAULT = 16'hB9C0;

endpackage

// File: rtl/bpu_cnt_timer.sv
// Free-running auto-dump interval timer: pulses fire once every `period` cycles.
// A period of zero parks the timer at 0 and never fires.
module bpu_cnt_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] period,
    output logic        fire
);

    logic [15:0] timer_q;
    logic [15:0] timer_d;

    // A period lowered below the current count lets the timer run on and wrap.
    always_comb begin
        timer_d = timer_q + 16'd1;
        fire    = 1'b0;
        if (period == 16'd0) begin
            timer_d = 16'd0;
        end else if (timer_q == period - 16'd1) begin
            timer_d = 16'd0;
            fire    = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer_q <= 16'd0;
        end else begin
            timer_q <= timer_d;
        end
    end

endmodule

// File: rtl/bpu_cnt_reader.sv
// Snapshots five branch-statistics counters and streams them out as a
// 7-word valid/ready frame, on request or on a periodic auto trigger.
module bpu_cnt_reader
    import bpu_cnt_reader_pkg::*;
#(
    parameter logic [15:0] MAGIC  = MAGIC_DEFAULT,
    parameter int          NWORDS = NWORDS_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] jb_cnt,
    input  logic [31:0] wrong_cnt,
    input  logic [31:0] j_cnt,
    input  logic [31:0] b_cnt,
    input  logic [31:0] r_cnt,
    input  logic        dump_req,
    input  logic [15:0] auto_period,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic [2:0]  out_idx,
    output logic        out_last,
    output logic        busy,
    output logic [7:0]  dump_cnt
);

    localparam logic [2:0] LAST_IDX = 3'(NWORDS - 1);

    state_e      state_q, state_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_data_q, out_data_d;
    logic [2:0]  out_idx_q, out_idx_d;
    logic        out_last_q, out_last_d;
    logic        pending_q, pending_d;
    logic [7:0]  dump_cnt_q, dump_cnt_d;
    logic [31:0] snap_q [NCNT];
    logic [31:0] snap_d [NCNT];
    logic [31:0] live   [NCNT];

    logic        auto_fire;
    logic        req_now;
    logic        trigger;
    logic [2:0]  idx_inc;
    logic [31:0] snap_xor;
    logic [31:0] next_word;

    bpu_cnt_timer u_timer (
        .clk    (clk),
        .reset  (reset),
        .period (auto_period),
        .fire   (auto_fire)
    );

    assign live[0] = jb_cnt;
    assign live[1] = wrong_cnt;
    assign live[2] = j_cnt;
    assign live[3] = b_cnt;
    assign live[4] = r_cnt;

    assign req_now = dump_req | auto_fire;
    assign trigger = req_now | pending_q;
    assign idx_inc = out_idx_q + 3'd1;

    always_comb begin
        snap_xor = 32'd0;
        for (int i = 0; i < NCNT; i++) begin
            snap_xor = snap_xor ^ snap_q[i];
        end
    end

    always_comb begin
        next_word = {MAGIC, HDR_LO};
        unique case (idx_inc)
            IDX_JB:    next_word = snap_q[0];
            IDX_WRONG: next_word = snap_q[1];
            IDX_J:     next_word = snap_q[2];
            IDX_B:     next_word = snap_q[3];
            IDX_R:     next_word = snap_q[4];
            IDX_XOR:   next_word = snap_xor;
            default:   next_word = {MAGIC, HDR_LO};
        endcase
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;
        out_last_d  = out_last_q;
        pending_d   = pending_q;
        dump_cnt_d  = dump_cnt_q;
        snap_d      = snap_q;

        unique case (state_q)
            ST_IDLE: begin
                if (trigger) begin
                    state_d     = ST_SEND;
                    out_valid_d = 1'b1;
                    out_idx_d   = IDX_HDR;
                    out_data_d  = {MAGIC, HDR_LO};
                    out_last_d  = 1'b0;
                    pending_d   = 1'b0;
                    snap_d      = live;
                end
            end
            ST_SEND: begin
                // One-deep queue: a second request while one is pending is lost.
                if (req_now) begin
                    pending_d = 1'b1;
                end
                if (out_ready) begin
                    if (out_last_q) begin
                        state_d     = ST_IDLE;
                        out_valid_d = 1'b0;
                        out_data_d  = 32'd0;
                        out_idx_d   = 3'd0;
                        out_last_d  = 1'b0;
                        dump_cnt_d  = dump_cnt_q + 8'd1;
                    end else begin
                        out_idx_d   = idx_inc;
                        out_data_d  = next_word;
                        out_last_d  = (idx_inc == LAST_IDX);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            out_data_q  <= 32'd0;
            out_idx_q   <= 3'd0;
            out_last_q  <= 1'b0;
            pending_q   <= 1'b0;
            dump_cnt_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
            pending_q   <= pending_d;
            dump_cnt_q  <= dump_cnt_d;
        end
    end

    for (genvar gi = 0; gi < NCNT; gi++) begin : g_snap
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                snap_q[gi] <= 32'd0;
            end else begin
                snap_q[gi] <= snap_d[gi];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q == ST_SEND);
    assign dump_cnt  = dump_cnt_q;

endmodule

// File: tb/tb_bpu_cnt_reader.sv
// Scoreboard bench: a frame-level model pushes expected words when a frame
// starts; a negedge monitor pops and compares each transferred word.
module tb_bpu_cnt_reader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] jb_cnt = '0, wrong_cnt = '0, j_cnt = '0, b_cnt = '0, r_cnt = '0;
    logic        dump_req = 1'b0;
    logic [15:0] auto_period = '0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [31:0] out_data;
    logic [2:0]  out_idx;
    logic        out_last;
    logic        busy;
    logic [7:0]  dump_cnt;

    bpu_cnt_reader dut (
        .clk         (clk),
        .reset       (reset),
        .jb_cnt      (jb_cnt),
        .wrong_cnt   (wrong_cnt),
        .j_cnt       (j_cnt),
        .b_cnt       (b_cnt),
        .r_cnt       (r_cnt),
        .dump_req    (dump_req),
        .auto_period (auto_period),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_idx     (out_idx),
        .out_last    (out_last),
        .busy        (busy),
        .dump_cnt    (dump_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        last;
        logic [2:0]  idx;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   m_left  = 0;   // words of the current frame still to transfer
    bit   m_pend  = 0;
    int   m_timer = 0;
    int   m_dumps = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_left = 0; m_pend = 0; m_timer = 0; m_dumps = 0;
            exp_q.delete();
        end else begin
            int  per;
            bit  fire;
            logic [31:0] w [7];
            per  = int'(auto_period);
            fire = (per != 0) && (m_timer == per - 1);
            if (per == 0 || fire) m_timer = 0;
            else m_timer = (m_timer + 1) % 65536;
            if (m_left == 0) begin
                if (dump_req || m_pend || fire) begin
                    w[0] = 32'hB9C0_0005;
                    w[1] = jb_cnt; w[2] = wrong_cnt; w[3] = j_cnt; w[4] = b_cnt; w[5] = r_cnt;
                    w[6] = jb_cnt ^ wrong_cnt ^ j_cnt ^ b_cnt ^ r_cnt;
                    for (int i = 0; i < 7; i++) exp_q.push_back({(i == 6), 3'(i), w[i]});
                    m_left = 7;
                    m_pend = 0;
                end
            end else begin
                if (dump_req || fire) m_pend = 1;
                if (out_ready) begin
                    m_left--;
                    if (m_left == 0) m_dumps = (m_dumps + 1) % 256;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    bit          stall_prev = 0;
    logic [31:0] prev_data;
    logic [2:0]  prev_idx;

    always @(negedge clk) begin
        if (reset) begin
            stall_prev = 0;
        end else begin
            exp_t e;
            check("valid", 32'(out_valid), 32'(m_left != 0));
            check("busy", 32'(busy), 32'(m_left != 0));
            check("dump_cnt", 32'(dump_cnt), 32'(m_dumps));
            if (stall_prev && out_valid) begin
                check("hold_data", out_data, prev_data);
                check("hold_idx", 32'(out_idx), 32'(prev_idx));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL word: got idx %0d data %0h, expected no transfer", out_idx, out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("word_data", out_data, e.data);
                    check("word_idx", 32'(out_idx), 32'(e.idx));
                    check("word_last", 32'(out_last), 32'(e.last));
                end
            end
            stall_prev = out_valid && !out_ready;
            prev_data  = out_data;
            prev_idx   = out_idx;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_req();
        dump_req = 1'b1;
        step();
        dump_req = 1'b0;
    endtask

    task automatic wait_idx(input logic [2:0] idx);
        int n = 0;
        while (!(out_valid && out_idx == idx) && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) begin
            n_checks++;
            $display("FAIL wait_idx: idx %0d never presented (valid=%0b idx=%0d)", idx, out_valid, out_idx);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || out_valid) && n < 500) begin
            step();
            n++;
        end
        if (n >= 500) begin
            n_checks++;
            $display("FAIL wait_idle: still busy=%0b after %0d cycles", busy, n);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_data"}, out_data, 32'd0);
        check({tag, "_idx"}, 32'(out_idx), 32'd0);
        check({tag, "_last"}, 32'(out_last), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_dump_cnt"}, 32'(dump_cnt), 32'd0);
    endtask

    initial begin
        int   d0;
        logic [15:0] periods [6];
        periods[0] = 16'd0; periods[1] = 16'd20; periods[2] = 16'd5;
        periods[3] = 16'd9; periods[4] = 16'd1;  periods[5] = 16'd13;

        step(); step();
        check_zero_outputs("reset_hold");
        reset = 1'b0;
        step();
        check_zero_outputs("reset_state");

        // basic frame
        out_ready = 1'b1;
        jb_cnt = 32'd10; wrong_cnt = 32'd3; j_cnt = 32'd1; b_cnt = 32'd2; r_cnt = 32'd0;
        pulse_req();
        check("basic_latency_idx0", {out_valid, 28'd0, out_idx}, {1'b1, 31'd0});
        check("basic_hdr", out_data, 32'hB9C0_0005);
        wait_idx(3'd6);
        check("basic_xor", out_data, 32'h0000_000A);
        check("basic_last", 32'(out_last), 32'd1);
        wait_idle();
        check("basic_dump_cnt", 32'(dump_cnt), 32'd1);

        // backpressure at idx2
        jb_cnt = 32'h1111; wrong_cnt = 32'd3; j_cnt = 32'h3333; b_cnt = 32'h4444; r_cnt = 32'h5555;
        pulse_req();
        wait_idx(3'd2);
        out_ready = 1'b0;
        repeat (3) begin
            step();
            check("bp_data", out_data, 32'd3);
            check("bp_idx", 32'(out_idx), 32'd2);
        end
        out_ready = 1'b1;
        wait_idle();

        // snapshot stability: counters churn during the frame
        jb_cnt = $urandom; wrong_cnt = $urandom; j_cnt = $urandom; b_cnt = $urandom; r_cnt = $urandom;
        pulse_req();
        while (busy) begin
            jb_cnt = $urandom; wrong_cnt = $urandom; j_cnt = $urandom; b_cnt = $urandom; r_cnt = $urandom;
            step();
        end

        // pending: request mid-frame and on the last word
        d0 = int'(dump_cnt);
        pulse_req();
        wait_idx(3'd2);
        pulse_req();
        wait_idx(3'd6);
        pulse_req();
        check("pend_gap_valid", 32'(out_valid), 32'd0);
        step();
        check("pend_restart", {out_valid, 28'd0, out_idx}, {1'b1, 31'd0});
        wait_idle();
        repeat (3) step();
        check("pend_dump_delta", 32'((int'(dump_cnt) - d0) & 255), 32'd2);

        // auto-dump
        auto_period = 16'd20;
        repeat (150) step();
        auto_period = 16'd0;
        wait_idle();
        d0 = int'(dump_cnt);
        repeat (60) step();
        check("auto_off_no_frames", 32'(dump_cnt), 32'(d0));

        // randomized mix
        for (int c = 0; c < 1800; c++) begin
            if (c % 300 == 0) auto_period = periods[$urandom_range(0, 5)];
            dump_req  = ($urandom_range(0, 9) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0) begin
                jb_cnt = $urandom; wrong_cnt = $urandom; j_cnt = $urandom;
                b_cnt = $urandom; r_cnt = $urandom;
            end
            step();
        end
        dump_req = 1'b0; auto_period = 16'd0; out_ready = 1'b1;
        repeat (3) step();
        wait_idle();

        // reset in the middle of a frame
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        pulse_req();
        wait_idx(3'd3);
        reset = 1'b1;
        #1;
        check_zero_outputs("midreset");
        step();
        reset = 1'b0;
        step();
        check("midreset_dump_cnt", 32'(dump_cnt), 32'd0);
        jb_cnt = 32'hDEAD_0001;
        pulse_req();
        check("after_reset_idx0", {out_valid, 28'd0, out_idx}, {1'b1, 31'd0});
        wait_idle();
        check("after_reset_dump_cnt", 32'(dump_cnt), 32'd1);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
